// File: rtl/host_command_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | host_command_sequencer_if                                                 |
// | Command, UART tx/rx and response signals of the host command sequencer.   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface host_command_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [1:0]                cmd_opcode;
  logic [DATA_WIDTH-1:0]     cmd_address;
  logic [DATA_WIDTH-1:0]     cmd_write_data;
  logic [DATA_WIDTH-1:0]     cmd_operand_a;
  logic [DATA_WIDTH-1:0]     cmd_operand_b;
  logic [3:0]                cmd_alu_function;
  logic [DATA_WIDTH-1:0]     tx_data;
  logic                      tx_valid;
  logic                      tx_busy;
  logic [DATA_WIDTH-1:0]     rx_data;
  logic                      rx_data_valid;
  logic                      parity_error;
  logic                      frame_error;
  logic [2*DATA_WIDTH-1:0]   response_data;
  logic                      response_valid;
  logic                      response_error;

  // Sequencer side.
  modport master (
    input  cmd_valid, cmd_opcode, cmd_address, cmd_write_data,
           cmd_operand_a, cmd_operand_b, cmd_alu_function,
           tx_busy, rx_data, rx_data_valid, parity_error, frame_error,
    output cmd_ready, tx_data, tx_valid,
           response_data, response_valid, response_error
  );

  // Host / UART side.
  modport slave (
    output cmd_valid, cmd_opcode, cmd_address, cmd_write_data,
           cmd_operand_a, cmd_operand_b, cmd_alu_function,
           tx_busy, rx_data, rx_data_valid, parity_error, frame_error,
    input  cmd_ready, tx_data, tx_valid,
           response_data, response_valid, response_error
  );
endinterface
`default_nettype wire

// File: rtl/host_command_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | host_command_sequencer                                                    |
// | Frames host commands into UART bytes and collects the response bytes.     |
// | Optional response timeout: define HOST_RESPONSE_TIMEOUT_EN.               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module host_command_sequencer #(
  parameter int DATA_WIDTH              = 8,
  parameter int RESPONSE_TIMEOUT_CYCLES = 4096
) (
  input  wire logic                 UART_clk,
  input  wire logic                 reset,
  host_command_sequencer_if.master  bus
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_ALU   = 2'd2;

  localparam logic [DATA_WIDTH-1:0] HDR_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] HDR_READ  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] HDR_ALU   = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] HDR_NOP   = DATA_WIDTH'(8'hDD);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    SEND           = 3'd1,
    WAIT_BUSY_HIGH = 3'd2,
    WAIT_BUSY_LOW  = 3'd3,
    WAIT_RESPONSE  = 3'd4,
    DONE           = 3'd5
  } state_t;

  state_t                state;
  logic [1:0]            opcode;
  logic [DATA_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [3:0]            alu_function;
  logic [1:0]            byte_index;
  logic [1:0]            rx_count;
  logic                  error_flag;

  logic [2:0]            frame_len;
  logic [1:0]            rx_expected;
  logic [DATA_WIDTH-1:0] frame_byte;
  logic                  last_byte;
  logic                  rx_bad;
  logic                  timer_expired;

  if (RESPONSE_TIMEOUT_CYCLES < 1) begin : g_timeout_param_check
    $error("RESPONSE_TIMEOUT_CYCLES must be at least 1");
  end

  // Frame layout and expected response length, decoded from the held opcode.
  always_comb begin
    frame_len   = 3'd2;
    rx_expected = 2'd2;
    frame_byte  = '0;
    case (opcode)
      OP_WRITE: begin
        frame_len   = 3'd3;
        rx_expected = 2'd0;
        case (byte_index)
          2'd0:    frame_byte = HDR_WRITE;
          2'd1:    frame_byte = address;
          default: frame_byte = write_data;
        endcase
      end
      OP_READ: begin
        frame_len   = 3'd2;
        rx_expected = 2'd1;
        case (byte_index)
          2'd0:    frame_byte = HDR_READ;
          default: frame_byte = address;
        endcase
      end
      OP_ALU: begin
        frame_len   = 3'd4;
        rx_expected = 2'd2;
        case (byte_index)
          2'd0:    frame_byte = HDR_ALU;
          2'd1:    frame_byte = operand_a;
          2'd2:    frame_byte = operand_b;
          default: frame_byte = DATA_WIDTH'(alu_function);
        endcase
      end
      default: begin
        frame_len   = 3'd2;
        rx_expected = 2'd2;
        case (byte_index)
          2'd0:    frame_byte = HDR_NOP;
          default: frame_byte = DATA_WIDTH'(alu_function);
        endcase
      end
    endcase
  end

  assign last_byte          = (({1'b0, byte_index} + 3'd1) == frame_len);
  assign rx_bad             = bus.parity_error || bus.frame_error;
  assign bus.response_error = error_flag;

`ifdef HOST_RESPONSE_TIMEOUT_EN
  localparam int TIMER_W = $clog2(RESPONSE_TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RESPONSE_TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer;

  // Counts idle cycles inside WAIT_RESPONSE; any received byte restarts it.
  always_ff @(posedge UART_clk) begin
    if (reset || (state != WAIT_RESPONSE) || bus.rx_data_valid) begin
      timer <= '0;
    end else if (!timer_expired) begin
      timer <= timer + 1'b1;
    end
  end

  assign timer_expired = (state == WAIT_RESPONSE) && (timer == TIMER_LAST);
`else
  assign timer_expired = 1'b0;
`endif

  always_ff @(posedge UART_clk) begin
    if (reset) begin
      state              <= IDLE;
      opcode             <= '0;
      address            <= '0;
      write_data         <= '0;
      operand_a          <= '0;
      operand_b          <= '0;
      alu_function       <= '0;
      byte_index         <= '0;
      rx_count           <= '0;
      error_flag         <= 1'b0;
      bus.cmd_ready      <= 1'b1;
      bus.tx_valid       <= 1'b0;
      bus.tx_data        <= '0;
      bus.response_valid <= 1'b0;
      bus.response_data  <= '0;
    end else begin
      bus.tx_valid       <= 1'b0;
      bus.response_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            opcode            <= bus.cmd_opcode;
            address           <= bus.cmd_address;
            write_data        <= bus.cmd_write_data;
            operand_a         <= bus.cmd_operand_a;
            operand_b         <= bus.cmd_operand_b;
            alu_function      <= bus.cmd_alu_function;
            byte_index        <= '0;
            rx_count          <= '0;
            error_flag        <= 1'b0;
            bus.response_data <= '0;
            bus.cmd_ready     <= 1'b0;
            state             <= SEND;
          end
        end
        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_data  <= frame_byte;
            bus.tx_valid <= 1'b1;
            state        <= WAIT_BUSY_HIGH;
          end
        end
        WAIT_BUSY_HIGH: begin
          if (bus.tx_busy) begin
            state <= WAIT_BUSY_LOW;
          end
        end
        WAIT_BUSY_LOW: begin
          if (!bus.tx_busy) begin
            byte_index <= byte_index + 2'd1;
            if (!last_byte) begin
              state <= SEND;
            end else if (rx_expected == 2'd0) begin
              bus.response_valid <= 1'b1;
              state              <= DONE;
            end else begin
              state <= WAIT_RESPONSE;
            end
          end
        end
        WAIT_RESPONSE: begin
          if (bus.rx_data_valid) begin
            if (rx_bad) begin
              error_flag         <= 1'b1;
              bus.response_valid <= 1'b1;
              state              <= DONE;
            end else begin
              // Low byte arrives first.
              if (rx_count[0]) begin
                bus.response_data[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.rx_data;
              end else begin
                bus.response_data[DATA_WIDTH-1:0] <= bus.rx_data;
              end
              rx_count <= rx_count + 2'd1;
              if ((rx_count + 2'd1) == rx_expected) begin
                bus.response_valid <= 1'b1;
                state              <= DONE;
              end
            end
          end else if (timer_expired) begin
            error_flag         <= 1'b1;
            bus.response_valid <= 1'b1;
            state              <= DONE;
          end
        end
        DONE: begin
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_host_command_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_host_command_sequencer                                                 |
// | Directed bench with a frame/response model and a per-cycle monitor.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_host_command_sequencer;
  localparam int DW  = 8;
  localparam int TMO = 16;
`ifdef HOST_RESPONSE_TIMEOUT_EN
  localparam int PRE_WAIT = 4;
`else
  localparam int PRE_WAIT = 40;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  host_command_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  host_command_sequencer #(
    .DATA_WIDTH(DW),
    .RESPONSE_TIMEOUT_CYCLES(TMO)
  ) dut (
    .UART_clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int fall_cyc = 0;
  int resp_cyc = 0;
  logic busy_at_edge = 1'b0;
  logic force_busy = 1'b0;
  logic prev_tx_valid = 1'b0;
  logic ready_next = 1'b0;

  // Model state: bytes still owed on tx, and the pending response.
  logic [7:0]  exp_tx[$];
  logic [7:0]  tx_log[$];
  logic        resp_pending = 1'b0;
  logic [15:0] exp_resp = '0;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rx_count_for(input logic [1:0] op);
    return (op == 2'd0) ? 0 : (op == 2'd1) ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    busy_at_edge <= bus.tx_busy;
  end

  // UART transmitter: busy for three cycles after each byte strobe.
  initial begin
    logic nb;
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (bus.tx_valid) busy_cnt = 3;
      nb = (busy_cnt > 0) || force_busy;
      if (bus.tx_busy && !nb) fall_cyc = cyc;
      bus.tx_busy = nb;
    end
  end

  // Monitor: compares every output cycle against the model.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_tx_valid = 1'b0;
        ready_next    = 1'b0;
      end else begin
        if (ready_next) begin
          check("ready_after_resp", bus.cmd_ready, 1'b1);
          ready_next = 1'b0;
        end
        if (bus.tx_valid) begin
          check("tx_while_busy", busy_at_edge, 1'b0);
          check("tx_single_cycle", prev_tx_valid, 1'b0);
          check("tx_expected", exp_tx.size() != 0, 1'b1);
          if (exp_tx.size() != 0) begin
            b = exp_tx.pop_front();
            check("tx_byte", bus.tx_data, b);
          end
          tx_log.push_back(bus.tx_data);
        end
        prev_tx_valid = bus.tx_valid;
        if (bus.response_valid) begin
          check("resp_expected", resp_pending, 1'b1);
          check("ready_during_resp", bus.cmd_ready, 1'b0);
          check("tx_left_at_resp", exp_tx.size(), 0);
          if (resp_pending) begin
            check("resp_err", bus.response_error, exp_err);
            if (!exp_err) check("resp_data", bus.response_data, exp_resp);
          end
          resp_pending = 1'b0;
          resp_cyc     = cyc;
          ready_next   = 1'b1;
        end
      end
    end
  end

  task automatic issue_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wd,
                           input logic [7:0] a, input logic [7:0] b, input logic [3:0] fn);
    int guard;
    exp_tx.delete();
    case (op)
      2'd0: begin exp_tx.push_back(8'hAA); exp_tx.push_back(addr); exp_tx.push_back(wd); end
      2'd1: begin exp_tx.push_back(8'hBB); exp_tx.push_back(addr); end
      2'd2: begin
        exp_tx.push_back(8'hCC); exp_tx.push_back(a);
        exp_tx.push_back(b);     exp_tx.push_back({4'h0, fn});
      end
      default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fn}); end
    endcase
    exp_resp     = '0;
    exp_err      = 1'b0;
    resp_pending = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_opcode       = op;
    bus.cmd_address      = addr;
    bus.cmd_write_data   = wd;
    bus.cmd_operand_a    = a;
    bus.cmd_operand_b    = b;
    bus.cmd_alu_function = fn;
    bus.cmd_valid        = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    // Captured fields must not follow the inputs after accept.
    bus.cmd_address      = 8'($urandom);
    bus.cmd_write_data   = 8'($urandom);
    bus.cmd_operand_a    = 8'($urandom);
    bus.cmd_operand_b    = 8'($urandom);
    bus.cmd_alu_function = 4'($urandom);
    bus.cmd_opcode       = 2'($urandom);
  endtask

  task automatic finish_cmd(input logic [1:0] op, input logic [7:0] r0, input logic [7:0] r1,
                            input int err_at, input int err_kind, input int pre_wait);
    int guard;
    int n;
    logic [7:0] rb;
    n = rx_count_for(op);
    guard = 0;
    while ((exp_tx.size() != 0 || bus.tx_busy) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("tx_drain_bound", guard < 300, 1'b1);
    repeat (pre_wait) @(negedge clk);
    if (n > 0) check("resp_held_off", resp_pending, 1'b1);
    for (int k = 0; k < n; k++) begin
      rb = (k == 0) ? r0 : r1;
      if (err_at == k) exp_err = 1'b1;
      else exp_resp[8*k +: 8] = rb;
      @(posedge clk);
      #1;
      bus.rx_data       = rb;
      bus.rx_data_valid = 1'b1;
      bus.parity_error  = (err_at == k) && (err_kind == 1);
      bus.frame_error   = (err_at == k) && (err_kind == 2);
      @(posedge clk);
      #1;
      bus.rx_data_valid = 1'b0;
      bus.parity_error  = 1'b0;
      bus.frame_error   = 1'b0;
      repeat (2) @(posedge clk);
      if (err_at == k) break;
    end
    guard = 0;
    while (resp_pending && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("resp_bound", resp_pending, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int s;
    int guard;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_address = '0;
    bus.cmd_write_data = '0; bus.cmd_operand_a = '0; bus.cmd_operand_b = '0;
    bus.cmd_alu_function = '0; bus.rx_data = '0; bus.rx_data_valid = 1'b0;
    bus.parity_error = 1'b0; bus.frame_error = 1'b0;
    // Reset dominates a concurrent command and received byte.
    repeat (2) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b1; bus.rx_data_valid = 1'b1; bus.rx_data = 8'h5A;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0; bus.rx_data_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_resp_valid", bus.response_valid, 1'b0);
    check("rst_resp_error", bus.response_error, 1'b0);
    check("rst_resp_data", bus.response_data, 16'h0000);

    // Write 05 <- 3C.
    s = tx_log.size();
    issue_cmd(2'd0, 8'h05, 8'h3C, 8'h00, 8'h00, 4'h0);
    finish_cmd(2'd0, 8'h00, 8'h00, -1, 0, 0);
    check("lit_write_tx", {tx_log[s], tx_log[s+1], tx_log[s+2]}, 24'hAA053C);
    check("lit_write_resp", {15'h0, bus.response_error, bus.response_data}, 32'h0000_0000);

    // Read 05 -> 3C, with a stray received byte during the frame.
    s = tx_log.size();
    issue_cmd(2'd1, 8'h05, 8'h00, 8'h00, 8'h00, 4'h0);
    bus.rx_data = 8'hEE; bus.rx_data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_data_valid = 1'b0;
    finish_cmd(2'd1, 8'h3C, 8'h00, -1, 0, PRE_WAIT);
    check("lit_read_tx", {tx_log[s], tx_log[s+1]}, 16'hBB05);
    check("lit_read_resp", bus.response_data, 16'h003C);
    repeat (5) @(negedge clk);
    check("lit_read_held", bus.response_data, 16'h003C);

    // ALU 12,34 fn 0 -> 0046, transmitter busy at command start.
    s = tx_log.size();
    force_busy = 1'b1;
    issue_cmd(2'd2, 8'h00, 8'h00, 8'h12, 8'h34, 4'h0);
    repeat (5) @(posedge clk);
    #1;
    force_busy = 1'b0;
    finish_cmd(2'd2, 8'h46, 8'h00, -1, 0, 0);
    check("lit_alu_tx", {tx_log[s], tx_log[s+1], tx_log[s+2], tx_log[s+3]}, 32'hCC123400);
    check("lit_alu_resp", bus.response_data, 16'h0046);

    // ALU 9A,BC fn F -> 5678, two full bytes.
    issue_cmd(2'd2, 8'h00, 8'h00, 8'h9A, 8'hBC, 4'hF);
    finish_cmd(2'd2, 8'h78, 8'h56, -1, 0, 0);
    check("lit_alu2_resp", bus.response_data, 16'h5678);

    // ALU-nop fn 2, parity error on first byte.
    s = tx_log.size();
    issue_cmd(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'h2);
    finish_cmd(2'd3, 8'h04, 8'h00, 0, 1, 0);
    check("lit_nop_tx", {tx_log[s], tx_log[s+1]}, 16'hDD02);
    check("lit_nop_err", bus.response_error, 1'b1);

    // ALU-nop fn 7, frame error on second byte.
    issue_cmd(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'h7);
    finish_cmd(2'd3, 8'h11, 8'h22, 1, 2, 0);
    check("lit_frame_err", bus.response_error, 1'b1);

    // Next accept clears the error and data.
    issue_cmd(2'd0, 8'hF0, 8'h0F, 8'h00, 8'h00, 4'h0);
    finish_cmd(2'd0, 8'h00, 8'h00, -1, 0, 0);
    check("lit_clear_after", {15'h0, bus.response_error, bus.response_data}, 32'h0000_0000);

    // Reset during the second byte of a write.
    s = tx_log.size();
    issue_cmd(2'd0, 8'h77, 8'h99, 8'h00, 8'h00, 4'h0);
    guard = 0;
    while (tx_log.size() < s + 2 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("mid_reset_reach", tx_log.size(), s + 2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_tx.delete();
    resp_pending = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_ready", bus.cmd_ready, 1'b1);
    check("mid_reset_tx_valid", bus.tx_valid, 1'b0);
    repeat (30) @(negedge clk);
    check("mid_reset_no_tx", tx_log.size(), s + 2);

    // Sequencer still usable after the abandoned command.
    issue_cmd(2'd1, 8'h42, 8'h00, 8'h00, 8'h00, 4'h0);
    finish_cmd(2'd1, 8'hA5, 8'h00, -1, 0, 0);
    check("lit_post_reset_read", bus.response_data, 16'h00A5);

`ifdef HOST_RESPONSE_TIMEOUT_EN
    // Read with no reply: error response 16 cycles after entering WAIT_RESPONSE.
    issue_cmd(2'd1, 8'h21, 8'h00, 8'h00, 8'h00, 4'h0);
    exp_err = 1'b1;
    guard = 0;
    while (resp_pending && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("timeout_resp_seen", resp_pending, 1'b0);
    check("timeout_latency", resp_cyc - fall_cyc, 17);
    check("timeout_err", bus.response_error, 1'b1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected end before 300000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/host_command_sequencer.md
HOST_COMMAND_SEQUENCER -- requirements
Module: host_command_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of a UART byte, register address and operand.
REQ-002 Parameter RESPONSE_TIMEOUT_CYCLES, default 4096, response-wait limit in UART_clk cycles (used only with REQ-033).
REQ-003 UART_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE.
REQ-007 cmd_opcode  in  2  0=register write, 1=register read, 2=ALU with operands, 3=ALU without operands.
REQ-008 cmd_address, cmd_write_data, cmd_operand_a, cmd_operand_b  in  DATA_WIDTH each  command fields.
REQ-009 cmd_alu_function  in  4  ALU function code, zero-extended to DATA_WIDTH when sent.
REQ-010 tx_data  out  DATA_WIDTH;  tx_valid  out  1  byte-send strobe to UART transmitter.
REQ-011 tx_busy  in  1  UART transmitter busy.
REQ-012 rx_data  in  DATA_WIDTH;  rx_data_valid  in  1  one-cycle received-byte strobe.
REQ-013 parity_error, frame_error  in  1  receiver error flags, qualified by rx_data_valid.
REQ-014 response_data  out  2*DATA_WIDTH;  response_valid  out  1;  response_error  out  1.

Function
REQ-015 Accept: cmd_valid && cmd_ready captures all cmd_* fields into holding registers; later input changes ignored.
REQ-016 Frame bytes: write = AA, address, data; read = BB, address; ALU-op = CC, A, B, function; ALU-nop = DD, function.
REQ-017 Expected response bytes: write 0, read 1, ALU (both) 2 (low byte first, then high byte).
REQ-018 FSM states: IDLE, SEND, WAIT_BUSY_HIGH, WAIT_BUSY_LOW, WAIT_RESPONSE, DONE.
REQ-019 IDLE -> SEND on accept; byte index cleared to 0.
REQ-020 SEND: when tx_busy low, tx_data = frame byte[index], tx_valid high exactly one cycle, -> WAIT_BUSY_HIGH; if tx_busy high, hold in SEND, tx_valid low.
REQ-021 WAIT_BUSY_HIGH -> WAIT_BUSY_LOW on tx_busy high; WAIT_BUSY_LOW -> on tx_busy low: increment index; SEND if bytes remain, else WAIT_RESPONSE (read/ALU) or DONE (write).
REQ-022 WAIT_RESPONSE: each rx_data_valid stores rx_data into response_data[DATA_WIDTH*k +: DATA_WIDTH], k = receive count; after the expected count -> DONE.
REQ-023 rx_data_valid with parity_error or frame_error in WAIT_RESPONSE: set error flag, -> DONE immediately.
REQ-024 rx_data_valid outside WAIT_RESPONSE ignored.
REQ-025 DONE: response_valid high exactly one cycle, response_error = error flag, -> IDLE; response_data/response_error held until the next accept.
REQ-026 Read: response_data upper byte = 0; write: response_data = 0.
REQ-027 response_data cleared to 0 and error flag cleared on each accept.
REQ-028 Latency: cmd_ready returns high the cycle after response_valid.

Reset
REQ-029 reset high on a clock edge: state IDLE, index and counters 0, holding registers 0.
REQ-030 Reset values: cmd_ready 1 (after reset released), tx_valid 0, tx_data 0, response_valid 0, response_error 0, response_data 0.
REQ-031 Reset mid-frame abandons the command with no response_valid; no further bytes sent.
REQ-032 reset dominates simultaneous cmd_valid or rx_data_valid.

Configuration
REQ-033 Macro HOST_RESPONSE_TIMEOUT_EN defined: counter runs in WAIT_RESPONSE, cleared on each rx_data_valid; reaching RESPONSE_TIMEOUT_CYCLES sets error flag -> DONE.
REQ-034 Macro undefined: no counter; WAIT_RESPONSE waits indefinitely.

Verification
REQ-035 Write opcode 0, address 0x05, data 0x3C -> tx bytes AA,05,3C; response_valid, data 0x0000, error 0; no rx needed.
REQ-036 Read opcode 1, address 0x05; rx 0x3C -> tx BB,05; response_data 0x003C, error 0.
REQ-037 ALU opcode 2, A 0x12, B 0x34, function 0; rx 0x46 then 0x00 -> tx CC,12,34,00; response_data 0x0046.
REQ-038 ALU opcode 3, function 2; rx 0x04 with parity_error=1 -> tx DD,02; response_valid with error 1 after first byte.
REQ-039 Reset pulsed during second tx byte of a write -> tx_valid stays 0, no response_valid, cmd_ready 1 next cycle.
REQ-040 With HOST_RESPONSE_TIMEOUT_EN, RESPONSE_TIMEOUT_CYCLES 16, read with no rx -> response_valid, error 1, 16 cycles after WAIT_RESPONSE entry.
